fibonacci_seq: RTL
==================

Name: fibonacci_seq

Overview:
Parametrised Fibonacci sequence generator with programmable seeds and term index. It has a start/busy/done control handshake and a valid/ready result port. Two modes:
- Final mode emits only F(n).
- Stream mode emits every term F(0)..F(n), one per accepted handshake.

It is the successor to the fixed 8-bit datapath, used wherever sequence terms feed downstream logic.

Parameters:
WIDTH, 8, data width of seeds, terms and result; all arithmetic is modulo 2^WIDTH.
IDX_WIDTH, 8, width of term index n and of the internal term counter.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high; returns block to IDLE.
start  in  1  request a run; sampled only in IDLE.
mode  in  1  0 = final-only, 1 = stream every term; latched on start acceptance.
n  in  IDX_WIDTH  index of last term; latched on start acceptance.
seed0  in  WIDTH  F(0); latched on start acceptance.
seed1  in  WIDTH  F(1); latched on start acceptance.
busy  out  1  high whenever state != IDLE.
out_valid  out  1  fib_out/out_last/overflow are valid.
out_ready  in  1  downstream accepts the current output.
fib_out  out  WIDTH  current term value.
out_last  out  1  current term is F(n).
overflow  out  1  sticky for the run: some term F(j), j<=n, wrapped modulo 2^WIDTH.
done  out  1  one-cycle pulse after the final handshake.

Behaviour:
Reset:
- Synchronous, active-high; overrides every other input, including mid-run.
- State goes to IDLE; busy, out_valid, out_last, overflow, done and fib_out all go to 0.
- Internal term registers and counter go to 0.

Datapath:
- Registers a = F(k), b = F(k+1), counter k.
- A step does: a <= b; b <= a+b (truncated to WIDTH bits); k <= k+1.
- The carry out of a+b sets overflow only when the produced term index k+2 <= n.

States: IDLE, RUN, EMIT.

IDLE:
- busy = 0, out_valid = 0.
- start = 1 latches mode, n, seed0 and seed1, sets a = seed0, b = seed1, k = 0, and clears overflow.
- On that acceptance: mode 0 goes to RUN; mode 1 goes to EMIT.

RUN (mode 0 only):
- If k == n, go to EMIT with no step.
- Otherwise perform one step per cycle.
- out_valid = 0 throughout.

EMIT:
- out_valid = 1, fib_out = a, out_last = (k == n).
- out_valid, fib_out and out_last stay stable while out_ready = 0.
- On out_ready = 1 with out_last = 1: go to IDLE, and done = 1 in the next cycle.
- On out_ready = 1 with out_last = 0 (stream mode only): perform a step and stay in EMIT. Throughput is one term per cycle with ready held high.

Latency, with start accepted at cycle t:
- Mode 0: first out_valid at t+n+2.
- Mode 1: F(0) valid at t+1.

Boundary conditions:
- start while busy: ignored, and no latched input changes.
- n = 0: the output is seed0 with out_last = 1 (either mode).
- n = 1: the output is seed1; no addition contributes to overflow.
- k never exceeds n, so the counter never wraps; n = 2^IDX_WIDTH-1 is legal.
- Changing start, mode, n or seeds during a run has no effect.
- overflow is valid whenever out_valid = 1. It stays readable until the next start acceptance or reset, then clears.
- done and start in the same cycle: the block is in IDLE, so start is accepted and done still pulses.

Test Plan:
1. WIDTH=8, mode 0, seeds 0/1, n=10 -> out_valid at t+12, fib_out=55, out_last=1, overflow=0; done pulses after the ready handshake.
2. mode 0, n=13 -> fib_out=233, overflow=0; then n=14 -> fib_out=121 (377 mod 256), overflow=1; overflow clears on the next start.
3. mode 1, n=5, out_ready held high -> fib_out 0,1,1,2,3,5 on consecutive cycles t+1..t+6, out_last only with 5, done at t+7.
4. mode 1, n=5, out_ready low for 3 cycles while showing the value 2 -> fib_out=2 with out_valid held; the stream resumes with 3 then 5 once ready rises; start pulses while busy are ignored.
5. mode 0, n=0, seeds 7/9 -> fib_out=7; n=1 -> fib_out=9; both with out_last=1 and overflow=0.
6. Reset asserted in EMIT mid-stream -> next cycle all outputs 0, state IDLE; a new start is accepted on the following cycle and runs correctly.

Source files
------------

// File: rtl/fibonacci_seq.sv
// Fibonacci sequence generator with programmable seeds and term index.
// Final mode emits only F(n); stream mode emits F(0)..F(n) over a valid/ready port.
module fibonacci_seq #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [IDX_WIDTH-1:0] n,
  input  logic [WIDTH-1:0]     seed0,
  input  logic [WIDTH-1:0]     seed1,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     fib_out,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [IDX_WIDTH-1:0]   k_q, k_d;
  logic [IDX_WIDTH-1:0]   n_q, n_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [WIDTH:0]         sum_w;
  logic [IDX_WIDTH:0]     next_idx_w;
  logic                   last_w;
  logic                   step_ovf_w;

  assign sum_w      = {1'b0, a_q} + {1'b0, b_q};
  assign next_idx_w = {1'b0, k_q} + (IDX_WIDTH+1)'(2);
  assign last_w     = (k_q == n_q);
  // A wrap only counts when the term being produced is still within F(0)..F(n).
  assign step_ovf_w = sum_w[WIDTH] && (next_idx_w <= {1'b0, n_q});

  // Handshake: a term transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, fib_out/out_last/overflow hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          a_d     = seed0;
          b_d     = seed1;
          k_d     = '0;
          ovf_d   = 1'b0;
          state_d = mode ? S_EMIT : S_RUN;
        end
      end
      S_RUN: begin
        if (last_w) begin
          state_d = S_EMIT;
        end else begin
          a_d   = b_q;
          b_d   = sum_w[WIDTH-1:0];
          k_d   = k_q + IDX_WIDTH'(1);
          ovf_d = ovf_q | step_ovf_w;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            a_d   = b_q;
            b_d   = sum_w[WIDTH-1:0];
            k_d   = k_q + IDX_WIDTH'(1);
            ovf_d = ovf_q | step_ovf_w;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_EMIT);
  assign fib_out   = out_valid ? a_q : '0;
  assign out_last  = out_valid && last_w;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
